// File: rtl/mosaic_pkg.sv
// rtl/mosaic_pkg.sv - shared scan states, default dimensions and address helper for the mosaic scan generator
package mosaic_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, PAUSE, DONE} scan_state_t;

  localparam int DEF_IMG_W  = 8;
  localparam int DEF_IMG_H  = 8;
  localparam int DEF_TILE_W = 4;
  localparam int DEF_TILE_H = 4;

  // Counter width that stays at least one bit even for a single-position range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] pix_addr(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] img_w);
    return y * img_w + x;
  endfunction

endpackage

// File: rtl/mosaic_tile_counter.sv
// rtl/mosaic_tile_counter.sv - nested px/py/tx/ty counter walking tiles in tile-major order
module mosaic_tile_counter
  import mosaic_pkg::*;
#(
  parameter int TILE_W  = DEF_TILE_W,
  parameter int TILE_H  = DEF_TILE_H,
  parameter int TILES_X = DEF_IMG_W / DEF_TILE_W,
  parameter int TILES_Y = DEF_IMG_H / DEF_TILE_H
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        adv,
  output logic [cnt_w(TILE_W)-1:0]    px,
  output logic [cnt_w(TILE_H)-1:0]    py,
  output logic [cnt_w(TILES_X)-1:0]   tx,
  output logic [cnt_w(TILES_Y)-1:0]   ty,
  output logic                        tile_last,
  output logic                        frame_last
);

  localparam int PX_W = cnt_w(TILE_W);
  localparam int PY_W = cnt_w(TILE_H);
  localparam int TX_W = cnt_w(TILES_X);
  localparam int TY_W = cnt_w(TILES_Y);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;
  logic [TX_W-1:0] tx_q, tx_d;
  logic [TY_W-1:0] ty_q, ty_d;
  logic px_max, py_max, tx_max, ty_max;

  assign px_max = (px_q == PX_W'(TILE_W - 1));
  assign py_max = (py_q == PY_W'(TILE_H - 1));
  assign tx_max = (tx_q == TX_W'(TILES_X - 1));
  assign ty_max = (ty_q == TY_W'(TILES_Y - 1));

  // Wrap each level by comparing to its maximum so non power-of-two sizes count correctly.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (adv) begin
      if (!px_max) begin
        px_d = px_q + 1'b1;
      end else begin
        px_d = '0;
        if (!py_max) begin
          py_d = py_q + 1'b1;
        end else begin
          py_d = '0;
          if (!tx_max) begin
            tx_d = tx_q + 1'b1;
          end else begin
            tx_d = '0;
            ty_d = ty_max ? '0 : ty_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

  assign px         = px_q;
  assign py         = py_q;
  assign tx         = tx_q;
  assign ty         = ty_q;
  assign tile_last  = px_max && py_max;
  assign frame_last = px_max && py_max && tx_max && ty_max;

endmodule

// File: rtl/mosaic_scan_gen.sv
// rtl/mosaic_scan_gen.sv - tile-major pixel address generator with valid/ready output and done pulse
// Optional MOSAIC_SCAN_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module mosaic_scan_gen
  import mosaic_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int TILE_W = DEF_TILE_W,
  parameter int TILE_H = DEF_TILE_H,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(IMG_W)-1:0] out_x,
  output logic [$clog2(IMG_H)-1:0] out_y,
  output logic                     tile_last,
  output logic                     frame_last,
`ifdef MOSAIC_SCAN_STALL_CNT_EN
  output logic [15:0]              stall_cnt,
`endif
  output logic                     done
);

  localparam int X_W     = $clog2(IMG_W);
  localparam int Y_W     = $clog2(IMG_H);
  localparam int TILES_X = IMG_W / TILE_W;
  localparam int TILES_Y = IMG_H / TILE_H;

  if ((IMG_W % TILE_W) != 0 || (IMG_H % TILE_H) != 0) begin : g_bad_dims
    $fatal(1, "mosaic_scan_gen: image dimensions must be multiples of tile dimensions");
  end

  logic [cnt_w(TILE_W)-1:0]  cnt_px;
  logic [cnt_w(TILE_H)-1:0]  cnt_py;
  logic [cnt_w(TILES_X)-1:0] cnt_tx;
  logic [cnt_w(TILES_Y)-1:0] cnt_ty;
  logic cnt_tile_last, cnt_frame_last;
  logic load, clear, xfer;
  logic [31:0] x_full, y_full;

  scan_state_t       state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [X_W-1:0]    out_x_q, out_x_d;
  logic [Y_W-1:0]    out_y_q, out_y_d;
  logic              tile_last_q, tile_last_d;
  logic              frame_last_q, frame_last_d;
  logic              done_q, done_d;
`ifdef MOSAIC_SCAN_STALL_CNT_EN
  logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

  // The counter always holds the next coordinate to present, so it advances on each load.
  mosaic_tile_counter #(
    .TILE_W  (TILE_W),
    .TILE_H  (TILE_H),
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y)
  ) u_cnt (
    .clk        (clk),
    .rst        (reset),
    .adv        (load),
    .px         (cnt_px),
    .py         (cnt_py),
    .tx         (cnt_tx),
    .ty         (cnt_ty),
    .tile_last  (cnt_tile_last),
    .frame_last (cnt_frame_last)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    tile_last_d  = tile_last_q;
    frame_last_d = frame_last_q;
    done_d       = 1'b0;
    load         = 1'b0;
    clear        = 1'b0;
    xfer         = out_valid_q & out_ready;
    x_full       = 32'(cnt_tx) * 32'(TILE_W) + 32'(cnt_px);
    y_full       = 32'(cnt_ty) * 32'(TILE_H) + 32'(cnt_py);

    case (state_q)
      IDLE, PAUSE: begin
        if (en) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (frame_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            clear   = 1'b1;
          end else if (en) begin
            load = 1'b1;
          end else begin
            state_d = PAUSE;
            clear   = 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (load) begin
      out_valid_d  = 1'b1;
      out_addr_d   = ADDR_W'(pix_addr(x_full, y_full, 32'(IMG_W)));
      out_x_d      = X_W'(x_full);
      out_y_d      = Y_W'(y_full);
      tile_last_d  = cnt_tile_last;
      frame_last_d = cnt_frame_last;
    end else if (clear) begin
      out_valid_d  = 1'b0;
      out_addr_d   = '0;
      out_x_d      = '0;
      out_y_d      = '0;
      tile_last_d  = 1'b0;
      frame_last_d = 1'b0;
    end
  end

`ifdef MOSAIC_SCAN_STALL_CNT_EN
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      tile_last_q  <= 1'b0;
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef MOSAIC_SCAN_STALL_CNT_EN
      stall_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      tile_last_q  <= tile_last_d;
      frame_last_q <= frame_last_d;
      done_q       <= done_d;
`ifdef MOSAIC_SCAN_STALL_CNT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign tile_last  = tile_last_q;
  assign frame_last = frame_last_q;
  assign done       = done_q;
`ifdef MOSAIC_SCAN_STALL_CNT_EN
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
